// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI target and its CRC helper.
package spi_pkg;

    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [15:0] CRC16_INIT        = 16'h0000;
    localparam logic [7:0]  IDLE_BYTE_DEFAULT = 8'hFF;

    typedef enum logic {
        DESELECTED = 1'b0,
        SELECTED   = 1'b1
    } spi_state_t;

endpackage

// File: rtl/crc16_byte.sv
// Combinational CRC-16 (poly 0x1021) advance by one byte, MSB first.
module crc16_byte
    import spi_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    always_comb begin
        crc_next = crc;
        for (int i = 7; i >= 0; i--) begin
            if (crc_next[15] ^ data[i])
                crc_next = {crc_next[14:0], 1'b0} ^ CRC16_POLY;
            else
                crc_next = {crc_next[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sclk/mosi/_ss, byte rx/tx with running CRC-16.
//
// state      | meaning
// -----------+------------------------------------------------
// DESELECTED | synchronised _ss high; sclk edges ignored
// SELECTED   | synchronised _ss low; shifting on sclk edges
module spi_target
    import spi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        _ss,
    output logic        miso,
    output logic        miso_oe,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ack,
    output logic        tx_underrun,
    output logic        frame_err,
    input  logic        crc_reset,
    output logic [15:0] crc_out,
    output logic        busy
);

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], _ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, mosi_s, ss_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;

    spi_state_t  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic        load_pending;

    logic [7:0]  tx_load_byte;
    logic [7:0]  rx_byte_next;
    logic [15:0] crc_calc;

    assign tx_load_byte = tx_valid ? tx_data : IDLE_BYTE;
    assign rx_byte_next = {rx_shift[6:0], mosi_s};

    crc16_byte u_crc (
        .crc      (crc_out),
        .data     (rx_byte_next),
        .crc_next (crc_calc)
    );

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state        <= DESELECTED;
            bit_cnt      <= 3'd0;
            rx_shift     <= 8'h00;
            tx_shift     <= 8'hFF;
            load_pending <= 1'b0;
            miso         <= 1'b1;
            miso_oe      <= 1'b0;
            busy         <= 1'b0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            tx_ack       <= 1'b0;
            tx_underrun  <= 1'b0;
            frame_err    <= 1'b0;
            crc_out      <= CRC16_INIT;
        end else begin
            rx_valid    <= 1'b0;
            tx_ack      <= 1'b0;
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
            if (crc_reset)
                crc_out <= CRC16_INIT;

            case (state)
                DESELECTED: begin
                    if (ss_fall) begin
                        state        <= SELECTED;
                        bit_cnt      <= 3'd0;
                        load_pending <= 1'b0;
                        tx_shift     <= tx_load_byte;
                        miso         <= tx_load_byte[7];
                        tx_ack       <= tx_valid;
                        tx_underrun  <= ~tx_valid;
                        miso_oe      <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                SELECTED: begin
                    if (sclk_rise) begin
                        rx_shift <= rx_byte_next;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rx_data      <= rx_byte_next;
                            rx_valid     <= 1'b1;
                            crc_out      <= crc_reset ? CRC16_INIT : crc_calc;
                            load_pending <= 1'b1;
                        end
                    end

                    // Deselect outranks a coincident sclk fall, so a master that drops
                    // sclk and raises _ss together does not trigger an extra load.
                    if (ss_rise) begin
                        if (sclk_rise ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0))
                            frame_err <= 1'b1;
                        state        <= DESELECTED;
                        bit_cnt      <= 3'd0;
                        load_pending <= 1'b0;
                        miso_oe      <= 1'b0;
                        busy         <= 1'b0;
                    end else if (sclk_fall) begin
                        if (load_pending) begin
                            tx_shift     <= tx_load_byte;
                            miso         <= tx_load_byte[7];
                            tx_ack       <= tx_valid;
                            tx_underrun  <= ~tx_valid;
                            load_pending <= 1'b0;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            miso     <= tx_shift[6];
                        end
                    end
                end

                default: state <= DESELECTED;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-banged SPI master with rx scoreboard queue.
module tb_spi_target;

    localparam int H = 5;

    logic        clk = 1'b0;
    logic        _reset;
    logic        sclk, mosi, _ss;
    logic        miso, miso_oe;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ack, tx_underrun, frame_err;
    logic        crc_reset;
    logic [15:0] crc_out;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0, und_cnt = 0, ferr_cnt = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [15:0] crc_exp;
    logic [7:0]  got;

    spi_target dut (
        .clk         (clk),
        ._reset      (_reset),
        .sclk        (sclk),
        .mosi        (mosi),
        ._ss         (_ss),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ack      (tx_ack),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .crc_reset   (crc_reset),
        .crc_out     (crc_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sel();
        _ss = 1'b0;
        ticks(6);
    endtask

    // Sends n bits MSB first; end_frame drops sclk and raises _ss together on the last fall.
    task automatic shift_bits(input logic [7:0] d, input int n, input bit end_frame,
                              output logic [7:0] g);
        g = 8'h00;
        for (int k = 0; k < n; k++) begin
            mosi = d[7-k];
            ticks(H);
            sclk = 1'b1;
            g[7-k] = miso;
            ticks(H);
            sclk = 1'b0;
            if (end_frame && k == n - 1)
                _ss = 1'b1;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input bit end_frame, output logic [7:0] g);
        rxq.push_back(d);
        crc_exp = crc_model(crc_exp, d);
        shift_bits(d, 8, end_frame, g);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && rxq.size() != 0; i++)
            ticks(1);
        check(tag, rxq.size(), 0);
    endtask

    // Monitor: pulse counters and rx scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_ack)      ack_cnt++;
            if (tx_underrun) und_cnt++;
            if (frame_err)   ferr_cnt++;
            if (rx_valid) begin
                if (rxq.size() == 0)
                    check("rx_unexpected_qsize", rxq.size(), 1);
                else
                    check("rx_data", rx_data, rxq.pop_front());
            end
        end
    end

    // Tx feeder: presents the next queued byte after each ack, else drops tx_valid.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_ack) begin
                if (txq.size() != 0) tx_data = txq.pop_front();
                else                 tx_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] msg [9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        _reset = 1'b0; sclk = 1'b0; mosi = 1'b0; _ss = 1'b1;
        tx_data = 8'h00; tx_valid = 1'b0; crc_reset = 1'b0;
        crc_exp = 16'h0000;
        ticks(3);
        check("rst_miso", miso, 1'b1);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_crc", crc_out, 16'h0000);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        _reset = 1'b1;
        ticks(3);

        // Single byte A5
        ferr_cnt = 0;
        sel();
        check("sel_busy", busy, 1'b1);
        check("sel_miso_oe", miso_oe, 1'b1);
        send_rx(8'hA5, 1, got);
        ticks(6);
        drain("a5_drain");
        check("a5_crc", crc_out, crc_model(16'h0000, 8'hA5));
        check("a5_crc_nonzero", crc_out != 16'h0000, 1'b1);
        check("a5_no_frame_err", ferr_cnt, 0);
        check("a5_deselect_oe", miso_oe, 1'b0);

        // Two offered tx bytes
        ack_cnt = 0; und_cnt = 0;
        tx_data = 8'h3C; tx_valid = 1'b1;
        txq.push_back(8'h81);
        sel();
        send_rx(8'h11, 0, got);
        check("tx_byte0", got, 8'h3C);
        send_rx(8'h22, 1, got);
        check("tx_byte1", got, 8'h81);
        ticks(6);
        drain("tx_drain");
        check("tx_ack_cnt", ack_cnt, 2);
        check("tx_underrun_cnt", und_cnt, 0);

        // Underrun for two bytes
        ack_cnt = 0; und_cnt = 0;
        sel();
        send_rx(8'h0F, 0, got);
        check("und_byte0", got, 8'hFF);
        send_rx(8'hF0, 1, got);
        check("und_byte1", got, 8'hFF);
        ticks(6);
        drain("und_drain");
        check("und_cnt", und_cnt, 2);
        check("und_ack_cnt", ack_cnt, 0);

        // CRC check string
        crc_reset = 1'b1; ticks(1); crc_reset = 1'b0;
        crc_exp = 16'h0000;
        check("crc_cleared", crc_out, 16'h0000);
        sel();
        for (int i = 0; i < 9; i++)
            send_rx(msg[i], i == 8, got);
        ticks(6);
        drain("crc_drain");
        check("crc_123456789", crc_out, 16'h31C3);

        // crc_reset held across a byte completion: clear wins
        crc_reset = 1'b1;
        sel();
        send_rx(8'h42, 1, got);
        ticks(6);
        drain("crc_clr_drain");
        crc_reset = 1'b0;
        crc_exp = 16'h0000;
        check("crc_clear_wins", crc_out, 16'h0000);

        // Partial byte then clean 7E
        ferr_cnt = 0;
        sel();
        shift_bits(8'hC8, 5, 1, got);
        ticks(6);
        check("partial_frame_err", ferr_cnt, 1);
        sel();
        send_rx(8'h7E, 1, got);
        ticks(6);
        drain("realign_drain");
        check("realign_rx_data", rx_data, 8'h7E);
        check("realign_frame_err", ferr_cnt, 1);
        check("realign_crc", crc_out, crc_exp);

        // Reset mid-byte
        tx_data = 8'h00; tx_valid = 1'b1;
        sel();
        shift_bits(8'hF0, 4, 0, got);
        ticks(4);
        check("pre_rst_miso", miso, 1'b0);
        _reset = 1'b0;
        #2;
        check("midrst_miso", miso, 1'b1);
        check("midrst_miso_oe", miso_oe, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_crc", crc_out, 16'h0000);
        check("midrst_busy", busy, 1'b0);
        _ss = 1'b1; mosi = 1'b0; tx_valid = 1'b0;
        ticks(2);
        _reset = 1'b1;
        crc_exp = 16'h0000;
        ticks(4);
        sel();
        send_rx(8'h5A, 1, got);
        ticks(6);
        drain("post_rst_drain");
        check("post_rst_rx_data", rx_data, 8'h5A);
        check("post_rst_crc", crc_out, crc_model(16'h0000, 8'h5A));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
